calendar_date: RTL and testbench
================================

// Module: calendar_date
// PURPOSE
//   Date keeper for the electronic clock: holds year/month/day as BCD, advances one day per
//   midnight carry from the time-of-day block, and lets the user step day, month or year
//   through three set inputs. Output is the packed 8-digit BCD date for the display mux.
// PARAMETERS
//   INIT_YEAR   16'h2000  reset year, 4 BCD digits (0000..9999)
//   INIT_MONTH  8'h01     reset month, 2 BCD digits (01..12)
//   INIT_DAY    8'h01     reset day, 2 BCD digits (01..days_in_month(INIT))
// PORTS
//   Clk        in   1   system clock; all state changes on rising edge
//   Reset_n    in   1   synchronous reset, ACTIVE-HIGH (name kept from codebase)
//   cnt_inc    in   3   user set strobes: [0] day+1, [1] month+1, [2] year+1
//   full_flag  in   1   midnight carry from time block; 1-cycle pulse per day rollover
//   Data       out  32  {year[15:0], month[7:0], day[7:0]}, all BCD
// BEHAVIOUR
//   - One clock, synchronous active-high reset. Reset_n=1 at an edge: Data <= {INIT_YEAR,
//     INIT_MONTH,INIT_DAY} (default 32'h2000_0101); cnt_inc edge-detect history <= 3'b000.
//   - Data is registered; each event updates Data at the same edge it is sampled (latency 1).
//   - cnt_inc is rising-edge detected per bit (keep cnt_inc_d): a bit held high for N cycles
//     produces exactly one increment; re-arm requires the bit to return to 0.
//   - Leap year: (Y%4==0 && Y%100!=0) || Y%400==0, computed on BCD year. Days in month:
//     31 for 1,3,5,7,8,10,12; 30 for 4,6,9,11; Feb 29 if leap else 28.
//   - full_flag=1 (normal run): day+1; if day==dim -> day=01, month+1; if month==12 ->
//     month=01, year+1; year 9999 -> 0000. Each high cycle counts one day.
//   - Day set (bit0 edge): day+1, day==dim -> 01; no carry into month.
//   - Month set (bit1 edge): month+1, 12 -> 01; no carry into year; then clamp day to dim of
//     new month (e.g. 01-31 -> 02 gives 02-29 or 02-28).
//   - Year set (bit2 edge): year+1, 9999 -> 0000; then clamp day (02-29 -> 02-28 if non-leap).
//   - Priority in one cycle: reset > full_flag > cnt_inc. When full_flag applies, any
//     cnt_inc edges that cycle are dropped (history still updates). Among simultaneous
//     cnt_inc edges only the lowest set bit acts (day > month > year); others dropped.
//   - All BCD digits stay legal (0..9) at all times; no invalid date is ever output.
//   - Reset mid-operation overrides any pending event that cycle.
// TESTING
//   1. Reset 10 cycles, release, idle 50 cycles -> Data == 32'h2000_0101 throughout.
//   2. cnt_inc=3'b001 held 100 cycles then 0 -> Data == 32'h2000_0102 (single step only).
//   3. cnt_inc=3'b010 held, then 3'b100 held (each with 0 between) -> 32'h2001_0201 after
//      month then year steps from 2000-01-01.
//   4. Preload 1999-12-31 via params, pulse full_flag once -> 32'h2000_0101; from 2000-02-28
//      pulse -> 2000-02-29, again -> 2000-03-01; from 1900-02-28 pulse -> 1900-03-01.
//   5. Day set at 2000-04-30 -> 2000-04-01 (month unchanged); month set at 2000-01-31 ->
//      2000-02-29; year set at 2000-02-29 -> 2001-02-28; year set at 9999 -> 0000.
//   6. full_flag and cnt_inc[0] edge same cycle at 2000-01-05 -> 2000-01-06 (one step); reset
//      asserted concurrently with full_flag -> 32'h2000_0101.

Source files
------------

// File: rtl/calendar_date.sv
// BCD year/month/day keeper: advances on the midnight carry, user-steppable via edge-detected set strobes.
// Data is registered and updates on the same edge an event is sampled (latency 1).
module calendar_date #(
  parameter logic [15:0] INIT_YEAR  = 16'h2000,
  parameter logic [7:0]  INIT_MONTH = 8'h01,
  parameter logic [7:0]  INIT_DAY   = 8'h01
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [2:0]  cnt_inc,
  input  logic        full_flag,
  output logic [31:0] Data
);

  logic [2:0]  cnt_inc_d;
  logic [2:0]  edges;
  logic [15:0] year, year_inc, next_year;
  logic [7:0]  month, day, next_month, next_day, cur_dim;

  assign year  = Data[31:16];
  assign month = Data[15:8];
  assign day   = Data[7:0];
  assign edges = cnt_inc & ~cnt_inc_d;

  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] bcd2_bin(input logic [7:0] v);
    return ({3'd0, v[7:4]} * 7'd10) + {3'd0, v[3:0]};
  endfunction

  // Divisibility by 4 only needs the low two binary bits of each two-digit half.
  function automatic logic is_leap(input logic [15:0] y);
    logic [6:0] lo, hi;
    lo = bcd2_bin(y[7:0]);
    hi = bcd2_bin(y[15:8]);
    return ((lo[1:0] == 2'd0) && (lo != 7'd0)) || ((lo == 7'd0) && (hi[1:0] == 2'd0));
  endfunction

  function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic leap);
    case (m)
      8'h02:                     return leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                   return 8'h31;
    endcase
  endfunction

  // BCD ordering matches numeric ordering, so a plain compare clamps correctly.
  function automatic logic [7:0] clamp_day(input logic [7:0] d, input logic [7:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  always_comb begin
    next_year  = year;
    next_month = month;
    next_day   = day;
    year_inc   = bcd4_inc(year);
    cur_dim    = days_in_month(month, is_leap(year));
    if (full_flag) begin
      if (day == cur_dim) begin
        next_day = 8'h01;
        if (month == 8'h12) begin
          next_month = 8'h01;
          next_year  = year_inc;
        end else begin
          next_month = bcd2_inc(month);
        end
      end else begin
        next_day = bcd2_inc(day);
      end
    end else if (edges[0]) begin
      next_day = (day == cur_dim) ? 8'h01 : bcd2_inc(day);
    end else if (edges[1]) begin
      next_month = (month == 8'h12) ? 8'h01 : bcd2_inc(month);
      next_day   = clamp_day(day, days_in_month(next_month, is_leap(year)));
    end else if (edges[2]) begin
      next_year = year_inc;
      next_day  = clamp_day(day, days_in_month(month, is_leap(year_inc)));
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset_n) begin
      Data      <= {INIT_YEAR, INIT_MONTH, INIT_DAY};
      cnt_inc_d <= 3'b000;
    end else begin
      Data      <= {next_year, next_month, next_day};
      cnt_inc_d <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_calendar_date.sv
// Randomized and directed stimulus against an integer calendar model; a monitor pops expected dates each cycle.
module tb_calendar_date;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  cnt_inc = 3'b000;
  logic        full_flag = 1'b0;
  logic [31:0] data;

  int vectors = 0;
  int miscompares = 0;

  int my = 2000, mm = 1, md = 1;
  logic [2:0] prev_inc = 3'b000;
  logic [31:0] exp_q[$];

  calendar_date dut (
    .Clk(clk),
    .Reset_n(rst),
    .cnt_inc(cnt_inc),
    .full_flag(full_flag),
    .Data(data)
  );

  always #5 clk = ~clk;

  function automatic bit leap(input int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int dim(input int y, input int m);
    if (m == 2) return leap(y) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic logic [31:0] enc();
    return {4'(my / 1000), 4'((my / 100) % 10), 4'((my / 10) % 10), 4'(my % 10),
            4'(mm / 10), 4'(mm % 10), 4'(md / 10), 4'(md % 10)};
  endfunction

  task automatic model_apply(input logic [2:0] inc, input logic ff, input logic r);
    logic [2:0] e;
    if (r) begin
      my = 2000; mm = 1; md = 1;
      prev_inc = 3'b000;
      return;
    end
    e = inc & ~prev_inc;
    prev_inc = inc;
    if (ff) begin
      md++;
      if (md > dim(my, mm)) begin
        md = 1;
        mm++;
        if (mm > 12) begin
          mm = 1;
          my = (my + 1) % 10000;
        end
      end
    end else if (e[0]) begin
      md = (md == dim(my, mm)) ? 1 : md + 1;
    end else if (e[1]) begin
      mm = (mm == 12) ? 1 : mm + 1;
      if (md > dim(my, mm)) md = dim(my, mm);
    end else if (e[2]) begin
      my = (my + 1) % 10000;
      if (md > dim(my, mm)) md = dim(my, mm);
    end
  endtask

  task automatic step(input logic [2:0] inc, input logic ff, input logic r);
    @(negedge clk);
    cnt_inc   = inc;
    full_flag = ff;
    rst       = r;
    model_apply(inc, ff, r);
    exp_q.push_back(enc());
  endtask

  task automatic press(input int b);
    step(3'(1 << b), 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);
  endtask

  task automatic set_date(input int ty, input int tm, input int td);
    int n;
    n = (ty - my + 10000) % 10000;
    repeat (n) press(2);
    n = (tm - mm + 12) % 12;
    repeat (n) press(1);
    n = (td - md + dim(my, mm)) % dim(my, mm);
    repeat (n) press(0);
  endtask

  // Checks the value the most recent step produced, without adding an extra clock edge.
  task automatic check_now(input string name, input logic [31:0] want);
    @(posedge clk);
    #2;
    vectors++;
    if (data !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, data, want);
    end
  endtask

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (data !== e) begin
          miscompares++;
          $display("FAIL scoreboard @%0t: got %h expected %h", $time, data, e);
        end
      end
    end
  end

  initial begin : stim
    repeat (10) step(3'b000, 1'b0, 1'b1);
    repeat (50) step(3'b000, 1'b0, 1'b0);
    check_now("reset_idle", 32'h2000_0101);

    repeat (100) step(3'b001, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);
    check_now("day_hold_single", 32'h2000_0102);

    step(3'b000, 1'b0, 1'b1);
    repeat (5) step(3'b010, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);
    repeat (5) step(3'b100, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);
    check_now("month_then_year", 32'h2001_0201);

    step(3'b000, 1'b0, 1'b1);
    set_date(2000, 1, 5);
    step(3'b001, 1'b1, 1'b0);
    check_now("ff_with_day_edge", 32'h2000_0106);
    step(3'b000, 1'b1, 1'b1);
    check_now("reset_over_ff", 32'h2000_0101);

    set_date(2000, 2, 28);
    step(3'b000, 1'b1, 1'b0);
    check_now("leap_feb28", 32'h2000_0229);
    step(3'b000, 1'b1, 1'b0);
    check_now("leap_feb29", 32'h2000_0301);

    set_date(2000, 4, 30);
    press(0);
    check_now("day_set_wrap", 32'h2000_0401);

    set_date(2000, 1, 31);
    press(1);
    check_now("month_set_clamp", 32'h2000_0229);
    press(2);
    check_now("year_set_clamp", 32'h2001_0228);

    set_date(9999, 12, 31);
    press(2);
    check_now("year_set_wrap", 32'h0000_1231);
    step(3'b000, 1'b1, 1'b0);
    check_now("ff_new_year_0001", 32'h0001_0101);

    set_date(1900, 2, 28);
    step(3'b000, 1'b1, 1'b0);
    check_now("century_nonleap", 32'h1900_0301);

    set_date(1999, 12, 31);
    step(3'b000, 1'b1, 1'b0);
    check_now("ff_year_carry", 32'h2000_0101);

    for (int i = 0; i < 3000; i++) begin
      logic [2:0] inc;
      inc = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'b000;
      step(inc, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 299) == 0));
    end
    step(3'b000, 1'b0, 1'b0);

    @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
